mobius_seq_ctrl: RTL
====================

Name: mobius_seq_ctrl

Overview:
- Iterative, area-compact Mobius transform engine over GF(2).
- Holds one N-bit vector in a working register and applies one butterfly stage per clock: stage 0 on the first cycle, stage log2_N-1 on the last.
- Sits between a producer and a consumer. Valid/ready handshakes on both sides. One transform in flight at a time.

Parameters:
- N, 4096, vector width in bits; must equal 2**log2_N.
- log2_N, 12, number of stages; must be >= 1.
- CNT_W, 4, width of the stage counter; must satisfy 2**CNT_W > log2_N.

Ports:
- clk  input  1  single clock, rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- in_valid  input  1  producer offers in_data.
- in_ready  output  1  block can accept a vector.
- in_data  input  [0:N-1]  input vector; bit 0 is index 0.
- out_valid  output  1  out_data holds a finished transform.
- out_ready  input  1  consumer accepts out_data.
- out_data  output  [0:N-1]  transformed vector; driven directly from the working register.
- busy  output  1  high in RUN state.
- stage  output  [CNT_W-1:0]  index of the stage applied on the next edge while in RUN; 0 otherwise.
- abort  input  1  present only when MOBIUS_ABORT_EN is defined.

Behaviour:
- Reset: asynchronous assert, synchronous release. While reset is asserted, all state clears: state=IDLE, working register=0, stage counter=0. Resulting outputs: in_ready=1, out_valid=0, busy=0, stage=0, out_data=0.
- Reset mid-operation discards the vector in progress. Nothing is emitted.
- Stage s butterfly operates on the working register R:
  - h = N >> (s+1).
  - For each block k in 0 .. 2**s-1, let b = k*2h. For each j in 0 .. h-1:
    - R'[b+j] = R[b+j]
    - R'[b+j+h] = R[b+j] ^ R[b+j+h]
  - Only one stage's logic is selected per cycle; the stage is chosen by a mux on the stage counter.
- Three-state FSM:
  - IDLE: in_ready=1. On in_valid&&in_ready: R <= in_data, counter <= 0, go to RUN.
  - RUN: in_ready=0, busy=1. Each edge: R <= stage(counter)(R).
    - If counter == log2_N-1: go to DONE, counter <= 0.
    - Otherwise: counter <= counter+1.
  - DONE: out_valid=1. R is held stable while out_valid=1 && !out_ready. On out_ready: go to IDLE.
- Latency: out_valid rises exactly log2_N cycles after the accepting edge. Throughput is one vector per log2_N+2 cycles at best.
- in_ready is high only in IDLE. There is no accept in the same cycle as an out handshake.
- out_ready asserted outside DONE is ignored. in_valid asserted outside IDLE is ignored; the producer must hold its data.
- out_data in IDLE/RUN shows R and is not valid; consumers must qualify it with out_valid.
- The counter never exceeds log2_N-1. No wrap-around is reachable.

Optional Feature:
- Macro: MOBIUS_ABORT_EN.
- Defined:
  - The abort input exists. abort=1 on any edge forces state to IDLE and counter to 0; R is kept.
  - abort has priority over every transition, including the in or out handshake in the same cycle. In that cycle the in handshake does not load R, and the out handshake does not count as a delivery.
  - abort in IDLE has no effect.
- Not defined:
  - No abort port. The FSM runs exactly as above.

Test Plan (N=8, log2_N=3, CNT_W=2; bit strings listed bit0..bit7):
1. Reset behaviour: assert rst_n=0 mid-RUN -> in the same cycle in_ready=1, out_valid=0, busy=0, stage=0, out_data=00000000; after release, a new vector is accepted normally.
2. Impulse vector: in_data=10000000, out_ready=1 held -> out_valid high 3 cycles after accept; stage reads 0,1,2 during RUN; out_data=11111111.
3. Top-bit and all-ones vectors: in_data=00000001 -> out_data=00000001; in_data=11111111 -> out_data=10000000.
4. Backpressure and involution:
   - in_data=10110010, out_ready=0 for 5 cycles -> out_valid stays 1, out_data stable, in_ready=0 throughout.
   - Feed that result back in -> out_data=10110010.
5. Handshake edges:
   - in_valid held during RUN/DONE -> no reload.
   - out_ready pulsed during RUN -> ignored.
   - Back-to-back vectors -> second accept no earlier than one cycle after the out handshake.
6. With MOBIUS_ABORT_EN: abort during stage 1 -> IDLE next cycle, out_valid never asserts. Abort coincident with in_valid in IDLE -> vector not loaded.

Source files
------------

// File: rtl/mobius_seq_ctrl.sv
// Iterative GF(2) Mobius transform engine: one butterfly stage per clock on a working register.
// Optional abort input is compiled in when MOBIUS_ABORT_EN is defined.
module mobius_seq_ctrl #(
    parameter int N      = 4096,
    parameter int log2_N = 12,
    parameter int CNT_W  = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [0:N-1]     in_data,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [0:N-1]     out_data,
    output logic             busy,
    output logic [CNT_W-1:0] stage
`ifdef MOBIUS_ABORT_EN
    ,
    input  logic             abort
`endif
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    localparam logic [CNT_W-1:0] LAST = CNT_W'(log2_N - 1);

    state_t           state;
    logic [0:N-1]     work;
    logic [CNT_W-1:0] cnt;
    logic             abort_i;
    logic [0:N-1]     stage_res [log2_N];
    logic [0:N-1]     run_next;

`ifdef MOBIUS_ABORT_EN
    assign abort_i = abort;
`else
    assign abort_i = 1'b0;
`endif

    // Upper half of each 2h-wide block picks up the XOR of its lower partner.
    always_comb begin
        for (int s = 0; s < log2_N; s++) begin
            for (int i = 0; i < N; i++) begin
                stage_res[s][i] = work[i];
                if ((i & (N >> (s + 1))) != 0)
                    stage_res[s][i] = work[i] ^ work[i - (N >> (s + 1))];
            end
        end
    end

    always_comb begin
        run_next = work;
        for (int s = 0; s < log2_N; s++)
            if (cnt == CNT_W'(s)) run_next = stage_res[s];
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state     <= IDLE;
            work      <= '0;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else if (abort_i) begin
            // Working register is deliberately left untouched.
            state     <= IDLE;
            cnt       <= '0;
            in_ready  <= 1'b1;
            out_valid <= 1'b0;
            busy      <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (in_valid) begin
                        work     <= in_data;
                        cnt      <= '0;
                        state    <= RUN;
                        in_ready <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                RUN: begin
                    work <= run_next;
                    if (cnt == LAST) begin
                        cnt       <= '0;
                        state     <= DONE;
                        busy      <= 1'b0;
                        out_valid <= 1'b1;
                    end else begin
                        cnt <= cnt + 1'b1;
                    end
                end
                DONE: begin
                    if (out_ready) begin
                        state     <= IDLE;
                        out_valid <= 1'b0;
                        in_ready  <= 1'b1;
                    end
                end
                default: begin
                    state     <= IDLE;
                    cnt       <= '0;
                    in_ready  <= 1'b1;
                    out_valid <= 1'b0;
                    busy      <= 1'b0;
                end
            endcase
        end
    end

    assign out_data = work;
    assign stage    = cnt;

endmodule
